// File: rtl/val2_pkg.sv
// Shared types and widths for the sequential Val2 operand generator.
// Optional carry support is selected with VAL2_SHIFTER_CARRY_EN.
package val2_pkg;

    localparam int WIDTH = 32;
    localparam int AMT_W = 6;
    localparam int K_W   = 4;
    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        LSL = 2'b00,
        LSR = 2'b01,
        ASR = 2'b10,
        ROR = 2'b11
    } kind_e;

    function automatic logic [WIDTH-1:0] sext12(input logic [11:0] v);
        return {{(WIDTH-12){v[11]}}, v};
    endfunction

endpackage

// File: rtl/val2_shift_step.sv
// One combinational shift/rotate step of up to STEP bits.
// carry_o (last bit moved out) exists only with VAL2_SHIFTER_CARRY_EN.
module val2_shift_step
    import val2_pkg::*;
(
    input  logic [WIDTH-1:0] acc_i,
    input  logic [1:0]       kind_i,
    input  logic [K_W-1:0]   k_i,
`ifdef VAL2_SHIFTER_CARRY_EN
    output logic             carry_o,
`endif
    output logic [WIDTH-1:0] res_o
);

    always_comb begin
        res_o = acc_i;
        unique case (kind_e'(kind_i))
            LSL: res_o = acc_i << k_i;
            LSR: res_o = acc_i >> k_i;
            ASR: res_o = $signed(acc_i) >>> k_i;
            ROR: res_o = (acc_i >> k_i) | (acc_i << (WIDTH - int'(k_i)));
            default: res_o = acc_i;
        endcase
    end

`ifdef VAL2_SHIFTER_CARRY_EN
    logic [IDX_W-1:0] idx_l;
    logic [IDX_W-1:0] idx_r;

    // k_i is never 0 when the carry is consumed, so the wrapped indices are harmless.
    always_comb begin
        idx_l   = IDX_W'(WIDTH - int'(k_i));
        idx_r   = IDX_W'(k_i) - 1'b1;
        carry_o = 1'b0;
        unique case (kind_e'(kind_i))
            LSL:     carry_o = acc_i[idx_l];
            LSR:     carry_o = acc_i[idx_r];
            ASR:     carry_o = acc_i[idx_r];
            ROR:     carry_o = res_o[WIDTH-1];
            default: carry_o = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/val2_seq_unit.sv
// Multi-cycle Val2 operand generator: shifts/rotates STEP bits per cycle.
// Define VAL2_SHIFTER_CARRY_EN to add carry_in/carry_out.
module val2_seq_unit
    import val2_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] Rm,
    input  logic [11:0] shift_operand,
    input  logic        imm,
    input  logic        Ld_St,
    input  logic        flush,
`ifdef VAL2_SHIFTER_CARRY_EN
    input  logic        carry_in,
    output logic        carry_out,
`endif
    output logic        ready,
    output logic        stall,
    output logic        done,
    output logic [31:0] val2
);

    localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(STEP);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [AMT_W-1:0]  amt_q, amt_d;
    logic [1:0]        kind_q, kind_d;
    logic [WIDTH-1:0]  val2_q, val2_d;

    logic [WIDTH-1:0]  ld_acc;
    logic [AMT_W-1:0]  ld_amt;
    logic [1:0]        ld_kind;
    logic [K_W-1:0]    k;
    logic [AMT_W-1:0]  amt_new;
    logic [WIDTH-1:0]  step_res;

`ifdef VAL2_SHIFTER_CARRY_EN
    logic carry_q, carry_d;
    logic step_carry;
`endif

    val2_shift_step u_step (
        .acc_i   (acc_q),
        .kind_i  (kind_q),
        .k_i     (k),
`ifdef VAL2_SHIFTER_CARRY_EN
        .carry_o (step_carry),
`endif
        .res_o   (step_res)
    );

    assign k       = (amt_q < STEP_AMT) ? K_W'(amt_q) : K_W'(STEP_AMT);
    assign amt_new = amt_q - AMT_W'(k);

    // Operand decode at accept: Ld_St beats imm beats shifted register.
    always_comb begin
        ld_acc  = Rm;
        ld_amt  = {1'b0, shift_operand[11:7]};
        ld_kind = shift_operand[6:5];
        if (Ld_St) begin
            ld_acc  = sext12(shift_operand);
            ld_amt  = '0;
            ld_kind = LSL;
        end else if (imm) begin
            ld_acc  = {24'b0, shift_operand[7:0]};
            ld_amt  = {1'b0, shift_operand[11:8], 1'b0};
            ld_kind = ROR;
        end
    end

    // NOTE: every variable gets a default first so no path leaves a latch.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        amt_d   = amt_q;
        kind_d  = kind_q;
        val2_d  = val2_q;
`ifdef VAL2_SHIFTER_CARRY_EN
        carry_d = carry_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    acc_d  = ld_acc;
                    amt_d  = ld_amt;
                    kind_d = ld_kind;
                    if (ld_amt == '0) begin
                        state_d = DONE;
                        val2_d  = ld_acc;
`ifdef VAL2_SHIFTER_CARRY_EN
                        carry_d = carry_in;
`endif
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = step_res;
                    amt_d = amt_new;
                    if (amt_new == '0) begin
                        state_d = DONE;
                        val2_d  = step_res;
`ifdef VAL2_SHIFTER_CARRY_EN
                        carry_d = step_carry;
`endif
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            amt_q   <= '0;
            kind_q  <= '0;
            val2_q  <= '0;
`ifdef VAL2_SHIFTER_CARRY_EN
            carry_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            amt_q   <= amt_d;
            kind_q  <= kind_d;
            val2_q  <= val2_d;
`ifdef VAL2_SHIFTER_CARRY_EN
            carry_q <= carry_d;
`endif
        end
    end

    assign ready = (state_q == IDLE);
    assign stall = start || (state_q != IDLE);
    assign done  = (state_q == DONE) && !flush;
    assign val2  = val2_q;
`ifdef VAL2_SHIFTER_CARRY_EN
    assign carry_out = carry_q;
`endif

endmodule

// File: tb/tb_val2_seq_unit.sv
// Directed self-checking bench for val2_seq_unit (STEP=1 and STEP=4 instances).
// Carry checks are compiled in with VAL2_SHIFTER_CARRY_EN.
module tb_val2_seq_unit;

    logic        clk = 1'b0;
    logic        rst, start, imm, Ld_St, flush;
    logic [31:0] Rm;
    logic [11:0] shift_operand;
    logic        ready, stall, done;
    logic [31:0] val2;
    logic        ready4, stall4, done4;
    logic [31:0] val2_4;
`ifdef VAL2_SHIFTER_CARRY_EN
    logic        carry_in, carry_out, carry_out4;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    val2_seq_unit #(.STEP(1)) dut (
        .clk(clk), .rst(rst), .start(start), .Rm(Rm), .shift_operand(shift_operand),
        .imm(imm), .Ld_St(Ld_St), .flush(flush),
`ifdef VAL2_SHIFTER_CARRY_EN
        .carry_in(carry_in), .carry_out(carry_out),
`endif
        .ready(ready), .stall(stall), .done(done), .val2(val2)
    );

    val2_seq_unit #(.STEP(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .Rm(Rm), .shift_operand(shift_operand),
        .imm(imm), .Ld_St(Ld_St), .flush(flush),
`ifdef VAL2_SHIFTER_CARRY_EN
        .carry_in(carry_in), .carry_out(carry_out4),
`endif
        .ready(ready4), .stall(stall4), .done(done4), .val2(val2_4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One accept, then count edges from the accept edge until done on each instance.
    task automatic run_op(input string tag, input logic ls, input logic im,
                          input logic [11:0] so, input logic [31:0] rm_v,
                          input int exp_lat, input int exp_lat4, input logic [31:0] exp_val);
        int lat, lat4;
        @(negedge clk);
        Ld_St = ls; imm = im; shift_operand = so; Rm = rm_v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; Rm = 32'hDEADBEEF; shift_operand = 12'h5A5;
        lat = 0; lat4 = 0;
        for (int c = 1; c <= 64; c++) begin
            if (done4 && lat4 == 0) lat4 = c;
            if (done) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_val"}, val2, exp_val);
        check({tag, "_stall"}, 32'(stall), 32'd1);
        check({tag, "_lat4"}, 32'(lat4), 32'(exp_lat4));
        check({tag, "_val4"}, val2_4, exp_val);
        @(posedge clk); #1;
        check({tag, "_ready"}, 32'(ready), 32'd1);
    endtask

    initial begin
        int pulses, pulses4, first;
        rst = 1'b1; start = 1'b0; imm = 1'b0; Ld_St = 1'b0; flush = 1'b0;
        Rm = '0; shift_operand = '0;
`ifdef VAL2_SHIFTER_CARRY_EN
        carry_in = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_val2", val2, 32'h0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        @(negedge clk); rst = 1'b0; #1;
        check("rst_ready", 32'(ready), 32'd1);

        run_op("ldst_neg", 1'b1, 1'b0, 12'hFFC, 32'h0,        1,  1, 32'hFFFFFFFC);
        run_op("imm_rot8", 1'b0, 1'b1, 12'h4FF, 32'h0,        9,  3, 32'hFF000000);
        run_op("asr4",     1'b0, 1'b0, 12'h240, 32'h80000010, 5,  2, 32'hF8000001);
        run_op("ror31",    1'b0, 1'b0, 12'hFE0, 32'h00000001, 32, 9, 32'h00000002);
        run_op("lsl0",     1'b0, 1'b0, 12'h000, 32'h00001234, 1,  1, 32'h00001234);
        run_op("lsr3",     1'b0, 1'b0, 12'h1A0, 32'hF0000000, 4,  2, 32'h1E000000);
        run_op("lsl5",     1'b0, 1'b0, 12'h280, 32'h08000001, 6,  3, 32'h00000020);
        run_op("imm_rot0", 1'b0, 1'b1, 12'h0AB, 32'h0,        1,  1, 32'h000000AB);
        run_op("ldst_pri", 1'b1, 1'b1, 12'h7FF, 32'h0,        1,  1, 32'h000007FF);

        // Flush in the third SHIFT cycle of LSR #10.
        @(negedge clk);
        Ld_St = 1'b0; imm = 1'b0; shift_operand = 12'h520; Rm = 32'hFFFF0000; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 flush = 1'b1;
        check("flush_done_now", 32'(done), 32'd0);
        @(posedge clk); #1 flush = 1'b0;
        check("flush_ready", 32'(ready), 32'd1);
        check("flush_ready4", 32'(ready4), 32'd1);
        check("flush_val2", val2, 32'h000007FF);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            if (done || done4) pulses++;
            @(posedge clk); #1;
        end
        check("flush_no_done", 32'(pulses), 32'd0);
        check("flush_val2_hold", val2, 32'h000007FF);

        // Asynchronous reset in the middle of a long ROR.
        @(negedge clk);
        shift_operand = 12'hFE0; Rm = 32'h1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_val2", val2, 32'h0);
        check("arst_val2_4", val2_4, 32'h0);
        check("arst_idle", 32'(stall), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        @(negedge clk); rst = 1'b0; #1;
        check("arst_ready", 32'(ready), 32'd1);

        // start held high: LSR #1 of 3, accepts every latency+1 = 3 cycles.
        @(negedge clk);
        Ld_St = 1'b0; imm = 1'b0; shift_operand = 12'h0A0; Rm = 32'h3; start = 1'b1;
`ifdef VAL2_SHIFTER_CARRY_EN
        carry_in = 1'b0;
`endif
        pulses = 0; pulses4 = 0; first = 0;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            check("held_stall", 32'(stall && stall4), 32'd1);
            if (done) begin
                pulses++;
                if (first == 0) first = c;
            end
            if (done4) pulses4++;
        end
        @(negedge clk); start = 1'b0;
        check("held_first", 32'(first), 32'd2);
        check("held_pulses", 32'(pulses), 32'd3);
        check("held_pulses4", 32'(pulses4), 32'd3);
        check("held_val2", val2, 32'h1);
`ifdef VAL2_SHIFTER_CARRY_EN
        check("held_carry", 32'(carry_out), 32'd1);
        check("held_carry4", 32'(carry_out4), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/val2_seq_unit.md
Name: val2_seq_unit

Overview:
- Multi-cycle, area-reduced replacement for the single-cycle Val2 operand generator in the EX stage.
- Shifts or rotates by at most STEP bits per cycle under an FSM, with a start/done handshake and a stall to the pipeline.
- Computes the same operand kinds: load/store 12-bit offset, rotated 8-bit immediate, and shifted register (LSL/LSR/ASR/ROR).

Parameters:
- STEP, 1, bits moved per SHIFT cycle; legal values 1, 2, 4, 8.
- WIDTH, 32, operand width; fixed at 32, kept symbolic for the package.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when ready=1.
- Rm  in  32  register operand; sampled at accept.
- shift_operand  in  12  instruction bits [11:0]; sampled at accept.
- imm  in  1  immediate-operand flag; sampled at accept.
- Ld_St  in  1  load/store flag; sampled at accept.
- flush  in  1  synchronous abort.
- ready  out  1  1 in IDLE only.
- stall  out  1  start OR state!=IDLE; holds the pipeline stage.
- done  out  1  one-cycle pulse; val2 is valid.
- val2  out  32  result; held until the next accept.

Behaviour:
- States: IDLE, SHIFT, DONE. 2-bit state register; state encoding comes from the package.
- Reset (any time, including mid-operation): state=IDLE, val2=0, done=0, internal accumulator and counter cleared. ready=1 once rst deasserts.
- Accept (IDLE && start): latch operands, load accumulator acc and remaining count amt. Priority order:
  - Ld_St=1: acc = sign-extended shift_operand; amt=0.
  - else imm=1: acc = {24'b0, shift_operand[7:0]}; kind=ROR; amt = 2*shift_operand[11:8] (6-bit, 0..30).
  - else: acc=Rm; kind=shift_operand[6:5] (00 LSL, 01 LSR, 10 ASR sign-fill, 11 ROR); amt=shift_operand[11:7] (0..31).
- After accept: amt==0 goes to DONE; otherwise goes to SHIFT.
- SHIFT, each cycle:
  - k = min(STEP, amt); acc shifted/rotated by k per kind; amt -= k.
  - Go to DONE when the new amt is 0.
  - LSL/LSR zero-fill; ASR replicates acc[31]; ROR wraps.
- DONE: val2 <= acc registered on the DONE entry edge; done=1 for exactly this cycle; next state is IDLE.
- A start asserted in DONE is not accepted (ready=0). Back-to-back spacing is therefore latency+1 cycles.
- Latency, start-accept edge to done: 1 + ceil(amt/STEP) cycles. Minimum 1, maximum 32 for STEP=1.
- Amount 0 for any kind: val2 = unmodified acc. No RRX special case; ROR #0 returns Rm.
- flush:
  - In SHIFT or DONE: next state IDLE, done suppressed (forced 0 that cycle), val2 keeps its previous value.
  - In IDLE: has priority over start, so no accept occurs.
- start while busy: ignored; no queueing.
- Operand inputs may change freely after accept.

Optional Feature:
- Macro: VAL2_SHIFTER_CARRY_EN.
- When defined:
  - Adds input carry_in (1) and output carry_out (1, reset 0), updated with val2.
  - carry_out = last bit shifted out: LSL gives the bit leaving [31]; LSR/ASR/ROR give the bit leaving [0].
  - carry_out = carry_in, latched at accept, when amt==0 or Ld_St=1.
  - For imm with nonzero rotate: carry_out = val2[31].
- When undefined: ports absent, no carry logic, all other behaviour identical.

Decomposition:
- Package val2_pkg holds:
  - state enum (IDLE/SHIFT/DONE);
  - shift kind enum with LSL=2'b00, LSR=2'b01, ASR=2'b10, ROR=2'b11;
  - WIDTH and the AMT_W=6 count width.
- Sub-module val2_shift_step: combinational single step of acc by k (0..STEP) for a given kind, with carry-out. Instantiated once; reused in every SHIFT cycle.

Test Plan:
- Ld_St=1, shift_operand=12'hFFC: done 1 cycle after accept, val2=32'hFFFFFFFC.
- imm=1, shift_operand=12'h4FF, STEP=1: done at cycle 9, val2=32'hFF000000.
- Register ASR: Rm=32'h80000010, shift_operand[11:7]=4, [6:5]=10, STEP=1: done at cycle 5, val2=32'hF8000001. Repeat with STEP=4: done at cycle 2, same val2.
- Register ROR #31 with Rm=32'h00000001: val2=32'h00000002 at cycle 32. LSL #0 with Rm=32'h1234: val2=32'h1234 at cycle 1.
- Flush and reset:
  - flush in 3rd SHIFT cycle of a LSR #10: no done pulse, ready=1 next cycle, val2 keeps its old value.
  - Async rst mid-SHIFT: val2=0 and state=IDLE immediately, without waiting for a clock edge.
- start held high continuously:
  - Accepts occur only in IDLE, spaced latency+1 apart.
  - stall=1 from the first start through DONE.
  - With VAL2_SHIFTER_CARRY_EN, LSR #1 of 32'h3 gives carry_out=1.
